// File: rtl/generic_fifo_rd_packer.sv
// Read-side drain for a non-show-ahead FIFO: prefetches through a 2-entry buffer,
// packs PACK words LSB-first and presents them on a valid/ready stream with flush.
module generic_fifo_rd_packer #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned PACK       = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_n_i,
   output logic                           fifo_rd_o,
   input  logic [DATA_WIDTH-1:0]          fifo_q_i,
   input  logic                           fifo_empty_i,
   input  logic                           flush_i,
   output logic                           src_valid_o,
   input  logic                           src_ready_i,
   output logic [DATA_WIDTH*PACK-1:0]     src_data_o,
   output logic [$clog2(PACK+1)-1:0]      src_words_o,
   output logic                           busy_o
);

   localparam int unsigned KW = (PACK > 1) ? $clog2(PACK) : 1;
   localparam int unsigned WW = $clog2(PACK + 1);
   localparam int unsigned OW = DATA_WIDTH * PACK;

   logic                  inflight;
   logic [DATA_WIDTH-1:0] buf_mem [2];
   logic                  buf_rd_ptr;
   logic                  buf_wr_ptr;
   logic [1:0]            buf_cnt;
   logic [KW-1:0]         k;
   logic [OW-1:0]         acc;
   logic                  flush_pend;

   logic [1:0]            occ;
   logic                  buf_has;
   logic [DATA_WIDTH-1:0] head;
   logic                  avail;
   logic                  out_free;
   logic                  pop;
   logic                  pop_buf;
   logic                  push;
   logic                  flush_go;
   logic                  emit_full;
   logic                  emit_part;
   logic                  flush_done;
   logic [OW-1:0]         acc_upd;
   int unsigned           slot_lsb;

   always_comb begin
      occ       = buf_cnt + {1'b0, inflight};
      fifo_rd_o = rst_n_i & !fifo_empty_i & !flush_pend & (occ < 2'd2);

      // With the buffer empty, the word arriving from the FIFO is consumed
      // directly so a lone read reaches the output two cycles later.
      buf_has  = (buf_cnt != 2'd0);
      head     = buf_has ? buf_mem[buf_rd_ptr] : fifo_q_i;
      avail    = buf_has | inflight;
      out_free = !src_valid_o | src_ready_i;
      pop      = out_free & avail;
      pop_buf  = pop & buf_has;
      push     = inflight & !(pop & !buf_has);

      flush_go   = flush_pend & !inflight & !buf_has;
      emit_full  = pop & (k == KW'(PACK - 1));
      emit_part  = flush_go & (k != '0) & out_free;
      flush_done = flush_go & ((k == '0) | out_free);

      slot_lsb = 32'(k) * DATA_WIDTH;
      acc_upd  = acc;
      acc_upd[slot_lsb +: DATA_WIDTH] = head;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         inflight   <= 1'b0;
         buf_mem[0] <= '0;
         buf_mem[1] <= '0;
         buf_rd_ptr <= 1'b0;
         buf_wr_ptr <= 1'b0;
         buf_cnt    <= '0;
         flush_pend <= 1'b0;
      end else begin
         inflight <= fifo_rd_o;
         if (push) begin
            buf_mem[buf_wr_ptr] <= fifo_q_i;
            buf_wr_ptr          <= ~buf_wr_ptr;
         end
         if (pop_buf) begin
            buf_rd_ptr <= ~buf_rd_ptr;
         end
         case ({push, pop_buf})
            2'b10:   buf_cnt <= buf_cnt + 2'd1;
            2'b01:   buf_cnt <= buf_cnt - 2'd1;
            default: buf_cnt <= buf_cnt;
         endcase
         // A flush arriving while one is being resolved is absorbed.
         flush_pend <= flush_done ? 1'b0 : (flush_pend | flush_i);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         k           <= '0;
         acc         <= '0;
         src_valid_o <= 1'b0;
         src_data_o  <= '0;
         src_words_o <= '0;
      end else if (emit_full || emit_part) begin
         src_valid_o <= 1'b1;
         src_data_o  <= emit_full ? acc_upd : acc;
         src_words_o <= emit_full ? WW'(PACK) : WW'(k);
         k           <= '0;
         acc         <= '0;
      end else begin
         if (src_ready_i) begin
            src_valid_o <= 1'b0;
         end
         if (pop) begin
            acc <= acc_upd;
            k   <= k + KW'(1);
         end
      end
   end

   assign busy_o = inflight | buf_has | (k != '0) | src_valid_o | flush_pend;

endmodule

// File: tb/tb_generic_fifo_rd_packer.sv
// Directed bench: PACK=2 instance for packing/backpressure/flush/reset,
// PACK=1 instance for latency, throughput and random ready.
module tb_generic_fifo_rd_packer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rd_a, empty_a, flush_a, valid_a, ready_a, busy_a;
   logic [15:0] q_a = '0;
   logic [31:0] data_a;
   logic [1:0]  words_a;

   logic        rd_b, empty_b, flush_b, valid_b, ready_b, busy_b;
   logic [15:0] q_b = '0;
   logic [15:0] data_b;
   logic [0:0]  words_b;

   generic_fifo_rd_packer #(.DATA_WIDTH(16), .PACK(2)) dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .fifo_rd_o(rd_a), .fifo_q_i(q_a),
      .fifo_empty_i(empty_a), .flush_i(flush_a), .src_valid_o(valid_a),
      .src_ready_i(ready_a), .src_data_o(data_a), .src_words_o(words_a),
      .busy_o(busy_a));

   generic_fifo_rd_packer #(.DATA_WIDTH(16), .PACK(1)) dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .fifo_rd_o(rd_b), .fifo_q_i(q_b),
      .fifo_empty_i(empty_b), .flush_i(flush_b), .src_valid_o(valid_b),
      .src_ready_i(ready_b), .src_data_o(data_b), .src_words_o(words_b),
      .busy_o(busy_b));

   // Non-show-ahead FIFO models: q valid the cycle after a read.
   logic [15:0] mem_a [256];
   logic [15:0] mem_b [256];
   int   wr_a = 0, rdi_a = 0, wr_b = 0, rdi_b = 0;
   logic rs_a = 1'b0, rs_b = 1'b0;

   assign empty_a = (wr_a == rdi_a);
   assign empty_b = (wr_b == rdi_b);

   always @(negedge clk) begin
      rs_a <= rd_a & !empty_a;
      rs_b <= rd_b & !empty_b;
   end
   always @(posedge clk) begin
      if (rs_a) begin q_a <= mem_a[rdi_a]; rdi_a <= rdi_a + 1; end
      if (rs_b) begin q_b <= mem_b[rdi_b]; rdi_b <= rdi_b + 1; end
   end

   logic [31:0] oa_data [$];
   int          oa_words [$];
   logic [15:0] ob_data [$];
   int          ob_cyc [$];
   int          first_rd_b = -1;

   always @(negedge clk) begin
      if (valid_a && ready_a) begin
         oa_data.push_back(data_a);
         oa_words.push_back(int'(words_a));
      end
      if (valid_b && ready_b) begin
         ob_data.push_back(data_b);
         ob_cyc.push_back(cyc);
      end
      if (rd_b && first_rd_b < 0) first_rd_b = cyc;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_a(input logic [15:0] w);
      mem_a[wr_a] = w;
      wr_a++;
   endtask

   task automatic push_b(input logic [15:0] w);
      mem_b[wr_b] = w;
      wr_b++;
   endtask

   task automatic wait_a(input int n, input int budget);
      int t = 0;
      while (oa_data.size() < n && t < budget) begin step(1); t++; end
      check("wait_a_timeout", 64'(oa_data.size() >= n), 64'd1);
   endtask

   task automatic wait_b(input int n, input int budget);
      int t = 0;
      while (ob_data.size() < n && t < budget) begin step(1); t++; end
      check("wait_b_timeout", 64'(ob_data.size() >= n), 64'd1);
   endtask

   initial begin
      int          base;
      int          n;
      logic        stable;
      logic [15:0] lo, hi;

      flush_a = 1'b0; ready_a = 1'b0; flush_b = 1'b0; ready_b = 1'b0;
      step(3);

      // Reset state, with the FIFO already holding data
      push_a(16'h1111); push_a(16'h2222); push_a(16'h3333); push_a(16'h4444);
      #1;
      check("rst_valid", 64'(valid_a), 64'd0);
      check("rst_rd",    64'(rd_a),    64'd0);
      check("rst_data",  64'(data_a),  64'd0);
      check("rst_words", 64'(words_a), 64'd0);
      check("rst_busy",  64'(busy_a),  64'd0);

      // 1: basic packing with ready=1
      step(1);
      rst_n = 1'b1;
      ready_a = 1'b1;
      wait_a(2, 30);
      check("t1_data0",  64'(oa_data[0]),  64'h22221111);
      check("t1_words0", 64'(oa_words[0]), 64'd2);
      check("t1_data1",  64'(oa_data[1]),  64'h44443333);
      check("t1_words1", 64'(oa_words[1]), 64'd2);
      step(3);
      check("t1_idle_busy", 64'(busy_a), 64'd0);

      // 2: backpressure, 10 words
      ready_a = 1'b0;
      base = rdi_a;
      for (int i = 0; i < 10; i++) push_a(16'h0a01 + 16'(i));
      step(20);
      check("t2_reads", 64'(rdi_a - base), 64'd4);
      check("t2_valid", 64'(valid_a), 64'd1);
      check("t2_data",  64'(data_a),  64'h0a020a01);
      stable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(1);
         if (valid_a !== 1'b1 || data_a !== 32'h0a020a01 || words_a !== 2'd2) stable = 1'b0;
      end
      check("t2_stable", 64'(stable), 64'd1);
      check("t2_reads_hold", 64'(rdi_a - base), 64'd4);
      ready_a = 1'b1;
      wait_a(7, 60);
      for (int i = 0; i < 5; i++) begin
         lo = 16'h0a01 + 16'(2 * i);
         hi = lo + 16'd1;
         check($sformatf("t2_data%0d", i), 64'(oa_data[2 + i]), 64'({hi, lo}));
         check($sformatf("t2_words%0d", i), 64'(oa_words[2 + i]), 64'd2);
      end

      // 3: partial word via flush
      push_a(16'h5555);
      step(6);
      check("t3_no_out", 64'(oa_data.size()), 64'd7);
      check("t3_busy_partial", 64'(busy_a), 64'd1);
      flush_a = 1'b1;
      step(1);
      flush_a = 1'b0;
      wait_a(8, 20);
      check("t3_data",  64'(oa_data[7]),  64'h00005555);
      check("t3_words", 64'(oa_words[7]), 64'd1);
      step(2);
      check("t3_busy_after", 64'(busy_a), 64'd0);

      // 4: flush with nothing held
      n = oa_data.size();
      flush_a = 1'b1;
      step(1);
      flush_a = 1'b0;
      check("t4_busy_pend", 64'(busy_a), 64'd1);
      step(1);
      check("t4_busy_clear", 64'(busy_a), 64'd0);
      step(3);
      check("t4_no_out", 64'(oa_data.size()), 64'(n));

      // 5: PACK=1 latency and throughput
      ready_b = 1'b1;
      for (int i = 0; i < 100; i++) push_b(16'h1000 + 16'(i));
      wait_b(100, 300);
      check("t5_latency", 64'(ob_cyc[0] - first_rd_b), 64'd2);
      check("t5_last_within", 64'(ob_cyc[99] - first_rd_b <= 102), 64'd1);
      for (int i = 0; i < 100; i++)
         check($sformatf("t5_seq%0d", i), 64'(ob_data[i]), 64'(16'h1000 + 16'(i)));

      // 5b: random ready
      for (int i = 0; i < 100; i++) push_b(16'h2000 + 16'(i));
      for (int t = 0; t < 2000 && ob_data.size() < 200; t++) begin
         ready_b = 1'($urandom_range(0, 1));
         step(1);
      end
      ready_b = 1'b1;
      wait_b(200, 20);
      step(5);
      check("t5r_count", 64'(ob_data.size()), 64'd200);
      for (int i = 0; i < 100; i++)
         check($sformatf("t5r_seq%0d", i), 64'(ob_data[100 + i]), 64'(16'h2000 + 16'(i)));

      // 6: reset mid-stream
      ready_a = 1'b0;
      push_a(16'h0d01); push_a(16'h0d02); push_a(16'h0d03);
      step(8);
      check("t6_pre_valid", 64'(valid_a), 64'd1);
      check("t6_pre_busy",  64'(busy_a),  64'd1);
      rst_n = 1'b0;
      #1;
      check("t6_valid", 64'(valid_a), 64'd0);
      check("t6_rd",    64'(rd_a),    64'd0);
      check("t6_data",  64'(data_a),  64'd0);
      check("t6_words", 64'(words_a), 64'd0);
      check("t6_busy",  64'(busy_a),  64'd0);
      step(2);
      rst_n = 1'b1;
      n = oa_data.size();
      ready_a = 1'b1;
      push_a(16'h0c01); push_a(16'h0c02);
      wait_a(n + 1, 30);
      check("t6_slot0_data",  64'(oa_data[n]),  64'h0c020c01);
      check("t6_slot0_words", 64'(oa_words[n]), 64'd2);
      step(4);
      check("t6_no_extra", 64'(oa_data.size()), 64'(n + 1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
